// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Parametrised single-clock FIFO. It buffers scan words between the scan
//   controller and the host-side bus bridge. Any DEPTH >= 2 is supported,
//   including depths that are not a power of two. The FIFO tracks exact
//   occupancy and provides threshold flags, sticky error flags and a
//   synchronous flush.
//
//   Optional feature (compile-time macro):
//     SYNC_FIFO_FWFT_EN  first-word fall-through. data_out always shows the
//                        head entry while the FIFO is not empty, and read
//                        pops it. When the macro is not defined, data_out is
//                        registered and loads the head entry on an accepted
//                        read (1-cycle read latency).
//
//   Parameters:
//     WIDTH     data word width in bits (>= 1)
//     DEPTH     number of storage entries (>= 2)
//     AF_LEVEL  almost_full  asserts when count >= AF_LEVEL
//     AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
//   Ports:
//     clk               rising-edge clock
//     rst_n             asynchronous active-low reset
//     clear             synchronous flush; overrides read and write
//     data_in           write data
//     write / read      push / pop requests
//     data_out          read data (registered, or head entry when FWFT)
//     count             occupancy, 0..DEPTH
//     fifo_full / fifo_not_full, fifo_empty / fifo_not_empty
//     almost_full / almost_empty
//     overflow / underflow   sticky error flags, cleared by reset or clear
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             fifo_full,
  output logic             fifo_not_full,
  output logic             fifo_empty,
  output logic             fifo_not_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             wr_ok,    rd_ok;

  // The pointer wraps by comparison so that non-power-of-two depths never
  // index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Flags are pure decodes of the occupancy register.
  assign fifo_full      = (count_q == FULL_CNT);
  assign fifo_not_full  = ~fifo_full;
  assign fifo_empty     = (count_q == '0);
  assign fifo_not_empty = ~fifo_empty;
  assign almost_full    = (int'(count_q) >= AF_LEVEL);
  assign almost_empty   = (int'(count_q) <= AE_LEVEL);
  assign count          = count_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;
  assign data_out       = dout_q;

  // A full FIFO still accepts a write when a read frees an entry in the same
  // cycle. An empty FIFO never accepts a read, even alongside a write.
  assign wr_ok = write & (~fifo_full | read);
  assign rd_ok = read  & fifo_not_empty;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (write & fifo_full & ~read) ovf_d = 1'b1;
      if (read & fifo_empty)         unf_d = 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Prefetch the head that will be current after this edge. If that slot is
  // the one being written right now, memory does not hold it yet, so take it
  // from data_in. With nothing left to show, keep the last head value.
  always_comb begin
    dout_d = dout_q;
    if (count_d != '0) begin
      dout_d = (wr_ok && (rd_ptr_d == wr_ptr_q)) ? data_in : mem_q[rd_ptr_d];
    end
  end
`else
  always_comb begin
    dout_d = dout_q;
    if (rd_ok && !clear) dout_d = mem_q[rd_ptr_q];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // NOTE: storage has no reset. The pointers and count alone decide which
  // entries are valid, and leaving the reset off lets the array map to RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed, self-checking bench for sync_fifo with WIDTH=8, DEPTH=5,
//   AF_LEVEL=4 and AE_LEVEL=1. A stimulus task drives one cycle at a time and
//   keeps a small occupancy model. Every accepted pop pushes its expected word
//   into a scoreboard queue. A separate monitor compares data_out against the
//   queue whenever the DUT completes a pop.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 5;
  localparam int AF_LEVEL = 4;
  localparam int AE_LEVEL = 1;
  localparam int CW       = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             fifo_full, fifo_not_full, fifo_empty, fifo_not_empty;
  logic             almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];     // model contents, head at index 0
  logic [WIDTH-1:0] exp_q[$];  // scoreboard of expected popped words
  bit               m_ov, m_un;
  logic [WIDTH-1:0] last_read;
  logic [WIDTH-1:0] held;

  sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
    .write(write), .read(read), .data_out(data_out), .count(count),
    .fifo_full(fifo_full), .fifo_not_full(fifo_not_full),
    .fifo_empty(fifo_empty), .fifo_not_empty(fifo_not_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a pop completes on an edge with read asserted on a
  // non-empty FIFO and no clear.
  always begin
    logic [WIDTH-1:0] got;
    @(posedge clk);
    if (rst_n && !clear && read && fifo_not_empty) begin
`ifdef SYNC_FIFO_FWFT_EN
      got = data_out;       // head presented before the popping edge
`else
      #1 got = data_out;    // registered read, valid after the edge
`endif
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no pop", got);
      end else begin
        check("pop_data", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},        32'(count),          32'(n));
    check({tag, ".full"},         32'(fifo_full),      32'(n == DEPTH));
    check({tag, ".not_full"},     32'(fifo_not_full),  32'(n != DEPTH));
    check({tag, ".empty"},        32'(fifo_empty),     32'(n == 0));
    check({tag, ".not_empty"},    32'(fifo_not_empty), 32'(n != 0));
    check({tag, ".almost_full"},  32'(almost_full),    32'(n >= AF_LEVEL));
    check({tag, ".almost_empty"}, 32'(almost_empty),   32'(n <= AE_LEVEL));
    check({tag, ".overflow"},     32'(overflow),       32'(m_ov));
    check({tag, ".underflow"},    32'(underflow),      32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    if (n != 0) check({tag, ".fwft_head"}, 32'(data_out), 32'(mq[0]));
`endif
  endtask

  // One clock cycle of stimulus: inputs change on the falling edge, the model
  // is updated from the pre-edge occupancy, and state is checked 1 after the
  // rising edge.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic c, input logic [WIDTH-1:0] d);
    bit full, empty;
    @(negedge clk);
    write = w; read = r; clear = c; data_in = d;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (c) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && full && !r) m_ov = 1'b1;
      if (r && empty)      m_un = 1'b1;
      if (r && !empty) begin
        last_read = mq.pop_front();
        exp_q.push_back(last_read);
      end
      if (w && (!full || r)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; clear = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; write = 1'b0; read = 1'b0; data_in = '0;
    m_ov = 1'b0; m_un = 1'b0; last_read = '0;
    #12 rst_n = 1'b1;
    check_state("reset");
    check("reset.data_out", 32'(data_out), 32'h0);

    // Asynchronous reset in the middle of a cycle with live state.
    step("ar_w1", 1, 0, 0, 8'h21);
    step("ar_r1", 0, 1, 0, 8'h00);
    step("ar_r2", 0, 1, 0, 8'h00);      // read on empty -> underflow
    step("ar_w2", 1, 0, 0, 8'h22);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst.count",        32'(count),        32'd0);
    check("async_rst.empty",        32'(fifo_empty),   32'd1);
    check("async_rst.almost_empty", 32'(almost_empty), 32'd1);
    check("async_rst.data_out",     32'(data_out),     32'h0);
    check("async_rst.overflow",     32'(overflow),     32'd0);
    check("async_rst.underflow",    32'(underflow),    32'd0);
    mq.delete(); m_ov = 1'b0; m_un = 1'b0; last_read = '0;
    @(negedge clk) rst_n = 1'b1;

    // Fill, overflow and drain.
    for (int i = 1; i <= 5; i++) begin
      step("fill", 1, 0, 0, 8'(8'h11 * i));
      if (i == 4) begin
        check("fill4.almost_full", 32'(almost_full), 32'd1);
        check("fill4.full",        32'(fifo_full),   32'd0);
      end
    end
    check("fill5.full", 32'(fifo_full), 32'd1);
    step("ovf", 1, 0, 0, 8'h66);
    check("ovf.overflow", 32'(overflow), 32'd1);
    check("ovf.count",    32'(count),    32'd5);
    for (int i = 0; i < 5; i++) step("drain", 0, 1, 0, 8'h00);
    check("drain.empty", 32'(fifo_empty), 32'd1);

    // Full with simultaneous read/write, including pointer wrap.
    for (int i = 1; i <= 5; i++) step("refill", 1, 0, 0, 8'(8'h11 * i));
    step("full_rw", 1, 1, 0, 8'hA0);
    check("full_rw.count", 32'(count), 32'd5);
`ifndef SYNC_FIFO_FWFT_EN
    check("full_rw.data_out", 32'(data_out), 32'h11);
`endif
    for (int i = 0; i < 12; i++) step("wrap_rw", 1, 1, 0, 8'(8'hB0 + i));
    for (int i = 0; i < 5; i++) step("wrap_drain", 0, 1, 0, 8'h00);

    // Empty corner cases.
    held = data_out;
    step("empty_rd", 0, 1, 0, 8'h00);
    check("empty_rd.underflow", 32'(underflow), 32'd1);
    check("empty_rd.data_out",  32'(data_out),  32'(held));
    step("empty_rw", 1, 1, 0, 8'h7E);
    check("empty_rw.count", 32'(count), 32'd1);
    step("empty_rw_pop", 0, 1, 0, 8'h00);

    // Clear with a concurrent write.
    for (int i = 1; i <= 3; i++) step("pre_clr", 1, 0, 0, 8'(8'h30 + i));
    held = data_out;
    step("clear", 1, 0, 1, 8'h99);
    check("clear.count",     32'(count),      32'd0);
    check("clear.empty",     32'(fifo_empty), 32'd1);
    check("clear.overflow",  32'(overflow),   32'd0);
    check("clear.underflow", 32'(underflow),  32'd0);
    check("clear.data_out",  32'(data_out),   32'(held));
    step("post_clr_w", 1, 0, 0, 8'h44);
    step("post_clr_r", 0, 1, 0, 8'h00);

`ifdef SYNC_FIFO_FWFT_EN
    step("fwft_w", 1, 0, 0, 8'h3C);
    check("fwft_w.data_out", 32'(data_out), 32'h3C);
    step("fwft_r", 0, 1, 0, 8'h00);
    check("fwft_r.empty",    32'(fifo_empty), 32'd1);
    check("fwft_r.data_out", 32'(data_out),   32'h3C);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
